// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator.
// Runs the horizontal/vertical position counters and produces sync pulses
// and a pixel-request coordinate one clock ahead of the active window. The
// content stage answers one clock later on pix_data. That data is gated onto
// rgb only while the active window is open.
module vga_ctrl #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   H_VALID  = 640,
  parameter int   H_FRONT  = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter int   V_VALID  = 480,
  parameter int   V_FRONT  = 10,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start
);

  // Totals and window edges. Every comparison runs at counter width.
  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int HS      = H_SYNC + H_BACK;
  localparam int VS      = V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_START = 10'(HS);
  localparam logic [9:0] H_ACT_END   = 10'(HS + H_VALID);
  localparam logic [9:0] H_REQ_START = 10'(HS - 1);
  localparam logic [9:0] H_REQ_END   = 10'(HS + H_VALID - 1);
  localparam logic [9:0] V_ACT_START = 10'(VS);
  localparam logic [9:0] V_ACT_END   = 10'(VS + V_VALID);
  localparam logic [9:0] POS_NONE    = 10'h3FF;

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;

  logic       h_active;
  logic       h_request;
  logic       v_active;

  // Position counters: cnt_h sweeps each line; cnt_v advances on the last clock of a line.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      cnt_h <= 10'd0;
      cnt_v <= 10'd0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= 10'd0;
      if (cnt_v == V_LAST) begin
        cnt_v <= 10'd0;
      end else begin
        cnt_v <= cnt_v + 10'd1;
      end
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  // Window decodes. The request window is the active window moved one clock earlier in x only.
  always_comb begin
    h_active  = (cnt_h >= H_ACT_START) && (cnt_h < H_ACT_END);
    h_request = (cnt_h >= H_REQ_START) && (cnt_h < H_REQ_END);
    v_active  = (cnt_v >= V_ACT_START) && (cnt_v < V_ACT_END);
  end

  // Output decode. Reset forces the idle levels so nothing leaks before the first frame.
  always_comb begin
    hsync       = SYNC_POL;
    vsync       = SYNC_POL;
    rgb_valid   = 1'b0;
    rgb         = 16'h0000;
    pix_x       = POS_NONE;
    pix_y       = POS_NONE;
    frame_start = 1'b0;
    if (sys_rst) begin
      hsync       = SYNC_POL;
      vsync       = SYNC_POL;
      rgb_valid   = 1'b0;
      rgb         = 16'h0000;
      pix_x       = POS_NONE;
      pix_y       = POS_NONE;
      frame_start = 1'b0;
    end else begin
      hsync       = (cnt_h < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      vsync       = (cnt_v < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      rgb_valid   = h_active && v_active;
      rgb         = (h_active && v_active) ? pix_data : 16'h0000;
      frame_start = (cnt_h == 10'd0) && (cnt_v == 10'd0);
      if (h_request && v_active) begin
        // The content stage answers one clock later, when cnt_h reaches the active column.
        pix_x = cnt_h - H_REQ_START;
        pix_y = cnt_v - V_ACT_START;
      end else begin
        pix_x = POS_NONE;
        pix_y = POS_NONE;
      end
    end
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: self-checking bench for vga_ctrl.
// Instance a uses the default 640x480 timing and is fed by a 1-clock content register.
// Instance b uses a small timing with positive sync, random pix_data and random resets.
`timescale 1ns/1ps
module tb_vga_ctrl;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        val;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [15:0] rgb;
    logic        fs;
  } out_t;

  typedef struct {
    int   hs, hb, hv, hf, vs, vb, vv, vf;
    logic pol;
  } tim_t;

  typedef struct {
    int          t;
    logic        frc;
    logic [15:0] fv;
    out_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance a signals
  logic        rst_a;
  logic [15:0] pd_a;
  logic [9:0]  px_a, py_a;
  logic        hs_a, vs_a, val_a, fs_a;
  logic [15:0] rgb_a;
  logic [15:0] cs_reg;
  logic        force_a;
  logic [15:0] force_val;

  // Instance b signals
  logic        rst_b;
  logic [15:0] pd_b;
  logic [9:0]  px_b, py_b;
  logic        hs_b, vs_b, val_b, fs_b;
  logic [15:0] rgb_b;

  out_t act_a, act_b;
  assign act_a = {hs_a, vs_a, val_a, px_a, py_a, rgb_a, fs_a};
  assign act_b = {hs_b, vs_b, val_b, px_b, py_b, rgb_b, fs_b};

  // Content stage model: registers {x[5:0], y} so the returned pixel encodes its own position.
  always @(posedge clk) cs_reg <= {px_a[5:0], py_a};
  assign pd_a = force_a ? force_val : cs_reg;

  vga_ctrl u_a (
    .vga_clk(clk), .sys_rst(rst_a), .pix_data(pd_a),
    .pix_x(px_a), .pix_y(py_a), .hsync(hs_a), .vsync(vs_a),
    .rgb_valid(val_a), .rgb(rgb_a), .frame_start(fs_a)
  );

  vga_ctrl #(
    .H_SYNC(4), .H_BACK(3), .H_VALID(10), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_VALID(6), .V_FRONT(2),
    .SYNC_POL(1'b1)
  ) u_b (
    .vga_clk(clk), .sys_rst(rst_b), .pix_data(pd_b),
    .pix_x(px_b), .pix_y(py_b), .hsync(hs_b), .vsync(vs_b),
    .rgb_valid(val_b), .rgb(rgb_b), .frame_start(fs_b)
  );

  // Reference: position derived from clocks elapsed since reset release.
  function automatic out_t model(input tim_t p, input int t, input logic rst, input logic [15:0] pd);
    int   ht, vt, h, v, hs0, vs0;
    logic vin, req;
    out_t o;
    ht  = p.hs + p.hb + p.hv + p.hf;
    vt  = p.vs + p.vb + p.vv + p.vf;
    h   = t % ht;
    v   = (t / ht) % vt;
    hs0 = p.hs + p.hb;
    vs0 = p.vs + p.vb;
    vin = (v >= vs0) && (v < vs0 + p.vv);
    o.hs  = (rst || h < p.hs) ? p.pol : ~p.pol;
    o.vs  = (rst || v < p.vs) ? p.pol : ~p.pol;
    o.val = !rst && vin && (h >= hs0) && (h < hs0 + p.hv);
    req   = !rst && vin && (h >= hs0 - 1) && (h < hs0 + p.hv - 1);
    o.px  = req ? 10'(h - hs0 + 1) : 10'h3FF;
    o.py  = req ? 10'(v - vs0) : 10'h3FF;
    o.rgb = o.val ? pd : 16'h0000;
    o.fs  = !rst && (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic out_t mk(input logic hs, input logic vs, input logic val, input logic [9:0] px,
                              input logic [9:0] py, input logic [15:0] rgb, input logic fs);
    out_t o;
    o = {hs, vs, val, px, py, rgb, fs};
    return o;
  endfunction

  task automatic check(input string nm, input out_t a, input out_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got hs=%b vs=%b val=%b x=%h y=%h rgb=%h fs=%b / expected hs=%b vs=%b val=%b x=%h y=%h rgb=%h fs=%b",
               nm, a.hs, a.vs, a.val, a.px, a.py, a.rgb, a.fs, e.hs, e.vs, e.val, e.px, e.py, e.rgb, e.fs);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  tim_t tp_a, tp_b;
  vec_t tbl[$];

  initial begin
    int idx;
    int t;
    int h, v;
    logic [15:0] pexp;
    bit did_mid;
    int prev_fs;
    bit have_prev;

    tp_a = '{hs:96, hb:48, hv:640, hf:16, vs:2, vb:33, vv:480, vf:10, pol:1'b0};
    tp_b = '{hs:4, hb:3, hv:10, hf:2, vs:2, vb:3, vv:6, vf:2, pol:1'b1};

    // Hand-derived vectors for the default timing (t = clocks since release, t = 800*v + h).
    tbl.push_back('{0,     1'b0, 16'h0, mk(1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b1)});
    tbl.push_back('{95,    1'b0, 16'h0, mk(1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0)});
    tbl.push_back('{96,    1'b0, 16'h0, mk(1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0)});
    tbl.push_back('{799,   1'b0, 16'h0, mk(1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0)});
    tbl.push_back('{800,   1'b0, 16'h0, mk(1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0)});
    tbl.push_back('{1599,  1'b0, 16'h0, mk(1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0)});
    tbl.push_back('{1600,  1'b0, 16'h0, mk(1'b0, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0)});
    tbl.push_back('{28142, 1'b0, 16'h0, mk(1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0)});
    tbl.push_back('{28143, 1'b1, 16'hFFFF, mk(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 16'h0000, 1'b0)});
    tbl.push_back('{28144, 1'b0, 16'h0, mk(1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 16'h0000, 1'b0)});
    tbl.push_back('{28145, 1'b0, 16'h0, mk(1'b1, 1'b1, 1'b1, 10'd2, 10'd0, 16'h0400, 1'b0)});
    tbl.push_back('{28782, 1'b0, 16'h0, mk(1'b1, 1'b1, 1'b1, 10'd639, 10'd0, 16'hF800, 1'b0)});
    tbl.push_back('{28783, 1'b0, 16'h0, mk(1'b1, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 16'hFC00, 1'b0)});
    tbl.push_back('{28784, 1'b1, 16'hFFFF, mk(1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0)});
    tbl.push_back('{28943, 1'b1, 16'hFFFF, mk(1'b1, 1'b1, 1'b0, 10'd0, 10'd1, 16'h0000, 1'b0)});
    tbl.push_back('{28944, 1'b0, 16'h0, mk(1'b1, 1'b1, 1'b1, 10'd1, 10'd1, 16'h0001, 1'b0)});

    rst_a = 1'b1; rst_b = 1'b1; force_a = 1'b0; force_val = 16'h0; pd_b = 16'hFFFF;

    // Reset hold: five clocks, outputs at idle levels.
    repeat (5) @(posedge clk);
    #2;
    check("reset_a", act_a, mk(1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0));
    check("reset_b", act_b, mk(1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000, 1'b0));

    // Instance a: table vectors plus per-clock model comparison, with a mid-frame reset.
    rst_a = 1'b0;
    t = 0; idx = 0; did_mid = 1'b0;
    for (int k = 0; k < 29201 + 1700; k++) begin
      h = t % 800;
      v = (t / 800) % 525;
      force_a   = !did_mid && idx < tbl.size() && tbl[idx].t == t && tbl[idx].frc;
      force_val = force_a ? tbl[idx].fv : 16'h0000;
      rst_a     = !did_mid && (t == 29200);
      #1;
      pexp = force_a ? force_val : {6'(h - 144), 10'(v - 35)};
      check($sformatf("a_t%0d", t), act_a, model(tp_a, t, rst_a, pexp));
      if (!did_mid && idx < tbl.size() && tbl[idx].t == t) begin
        check($sformatf("a_vec%0d", idx), act_a, tbl[idx].exp);
        idx++;
      end
      @(posedge clk);
      #1;
      if (rst_a) begin
        did_mid = 1'b1;
        t = 0;
      end else begin
        t++;
      end
    end
    check_int("a_vectors_applied", idx, tbl.size());
    rst_a = 1'b1;
    force_a = 1'b0;

    // Instance b: random pixel data and random resets against the model, plus frame spacing.
    rst_b = 1'b0;
    t = 0; have_prev = 1'b0; prev_fs = 0;
    for (int k = 0; k < 15000; k++) begin
      pd_b  = 16'($urandom);
      rst_b = (k == 2000) || ($urandom_range(0, 399) == 0);
      #1;
      check($sformatf("b_k%0d_t%0d", k, t), act_b, model(tp_b, t, rst_b, pd_b));
      if (rst_b) begin
        have_prev = 1'b0;
      end else if (fs_b) begin
        if (have_prev) check_int("b_frame_spacing", k - prev_fs, 247);
        prev_fs   = k;
        have_prev = 1'b1;
      end
      @(posedge clk);
      #1;
      t = rst_b ? 0 : t + 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
